// File: rtl/alu_stream_pkg.sv
// Shared types and constants for the ALU result byte streamer.
package alu_stream_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR  = 3'd1,
    ST_B3   = 3'd2,
    ST_B2   = 3'd3,
    ST_B1   = 3'd4,
    ST_B0   = 3'd5
  } state_e;

  localparam int FRAME_BYTES = 5;
  localparam int ENTRY_W     = 34;

  localparam logic [5:0] DEFAULT_HDR_TAG = 6'b101001;

  // Byte presented on the stream for a given serializer state.
  // Entry layout is {balance, equality, result[31:0]}.
  function automatic logic [7:0] frame_byte(input state_e             st,
                                            input logic [ENTRY_W-1:0] e,
                                            input logic [5:0]         tag);
    logic [7:0] b;
    b = 8'h00;
    case (st)
      ST_HDR:  b = {tag, e[33], e[32]};
      ST_B3:   b = e[31:24];
      ST_B2:   b = e[23:16];
      ST_B1:   b = e[15:8];
      ST_B0:   b = e[7:0];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/alu_result_streamer_fifo.sv
// Small synchronous FIFO holding captured ALU result entries.
// Full/empty come from the occupancy count; pointers wrap naturally.
module result_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 34
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         push,
  input  logic                         pop,
  input  logic [W-1:0]                 din,
  output logic [W-1:0]                 dout,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic [$clog2(DEPTH+1)-1:0]   count_nxt,
  output logic                         full,
  output logic                         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  // Next pointer/occupancy; flush wins over any push or pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      count_d = count_q + 1'b1;
      else if (!do_push && do_pop) count_d = count_q - 1'b1;
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are only meaningful below the count.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

  assign dout      = mem_q[rd_ptr_q];
  assign count     = count_q;
  assign count_nxt = count_d;

endmodule

// File: rtl/alu_result_streamer.sv
// Captures ALU results with their flags, queues them and streams each
// one out as a 5-byte frame: header {tag, balance, equality}, then the
// 32-bit result MSB first.
import alu_stream_pkg::*;

module alu_result_streamer #(
  parameter int         DEPTH   = 4,
  parameter logic [5:0] HDR_TAG = DEFAULT_HDR_TAG
) (
  input  logic                        Clk,
  input  logic                        reset,
  input  logic                        flush,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [31:0]                 output_num,
  input  logic                        balanceBit,
  input  logic                        equalityBit,
  output logic                        byte_valid,
  input  logic                        byte_ready,
  output logic [7:0]                  byte_data,
  output logic                        byte_last,
  output logic [$clog2(DEPTH+1)-1:0]  count
);

  localparam int CW = $clog2(DEPTH+1);

  state_e               state_q, state_d;
  logic [ENTRY_W-1:0]   frame_q, frame_d;
  logic                 in_ready_q, in_ready_d;
  logic                 byte_valid_q, byte_valid_d;
  logic [7:0]           byte_data_q, byte_data_d;
  logic                 byte_last_q, byte_last_d;

  logic                 push, pop;
  logic [ENTRY_W-1:0]   fifo_dout;
  logic [CW-1:0]        fifo_count, fifo_count_nxt;
  logic                 fifo_full, fifo_empty;

  assign push = in_valid && in_ready_q && !fifo_full && !flush;

  result_fifo #(
    .DEPTH (DEPTH),
    .W     (ENTRY_W)
  ) u_fifo (
    .clk       (Clk),
    .rst_n     (reset),
    .flush     (flush),
    .push      (push),
    .pop       (pop),
    .din       ({balanceBit, equalityBit, output_num}),
    .dout      (fifo_dout),
    .count     (fifo_count),
    .count_nxt (fifo_count_nxt),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // State, frame and registered outputs.
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      frame_q      <= '0;
      in_ready_q   <= 1'b0;
      byte_valid_q <= 1'b0;
      byte_data_q  <= 8'h00;
      byte_last_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      frame_q      <= frame_d;
      in_ready_q   <= in_ready_d;
      byte_valid_q <= byte_valid_d;
      byte_data_q  <= byte_data_d;
      byte_last_q  <= byte_last_d;
    end
  end

  // Serializer next state; pops from IDLE or straight out of B0 so
  // back-to-back frames leave no bubble.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    if (flush) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = ST_HDR;
        end
        ST_HDR: if (byte_ready) state_d = ST_B3;
        ST_B3:  if (byte_ready) state_d = ST_B2;
        ST_B2:  if (byte_ready) state_d = ST_B1;
        ST_B1:  if (byte_ready) state_d = ST_B0;
        ST_B0: if (byte_ready) begin
          if (!fifo_empty) begin
            pop     = 1'b1;
            state_d = ST_HDR;
          end else begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Output next values derived from the upcoming state and frame, so the
  // registered byte stays put whenever the state does not move.
  always_comb begin
    frame_d      = pop ? fifo_dout : frame_q;
    byte_valid_d = (state_d != ST_IDLE);
    byte_data_d  = frame_byte(state_d, frame_d, HDR_TAG);
    byte_last_d  = (state_d == ST_B0);
    in_ready_d   = (fifo_count_nxt != CW'(DEPTH));
  end

  assign in_ready   = in_ready_q;
  assign byte_valid = byte_valid_q;
  assign byte_data  = byte_data_q;
  assign byte_last  = byte_last_q;
  assign count      = fifo_count;

endmodule
